// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, default bit rate and oversample factor.
// Used by the transmitter and by receive-side monitors.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int unsigned BAUD_DEFAULT = 19200;
   localparam int unsigned OVERSAMPLE   = 16;

   // Divider reload value: one oversample tick is calc_div()+1 clk cycles.
   function automatic int unsigned calc_div(input int unsigned fcpu, input int unsigned baud);
      return fcpu / (baud * OVERSAMPLE) - 1;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter; power-of-two depth so the
// pointers wrap naturally. Pushes while full and pops while empty are dropped.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic                     push_i,
   input  logic [7:0]               data_i,
   input  logic                     pop_i,
   output logic [7:0]               data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign cnt_o   = cnt_q;
   assign data_o  = mem_q[rd_q];

   always_comb begin
      do_push = push_i & ~full_o;
      do_pop  = pop_i & ~empty_o;
      wr_d    = do_push ? wr_q + AW'(1) : wr_q;
      rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
      cnt_d   = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO, 16x oversample tick divider
// and a four-state framing FSM. txd is registered and idles high.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned FCPU       = 50000000,
   parameter int unsigned BAUD       = BAUD_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_b,
   input  logic                          tx_vld,
   input  logic [7:0]                    tx_data,
   output logic                          tx_rdy,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

   localparam int unsigned        DIV       = calc_div(FCPU, BAUD);
   localparam int                 DIV_W     = (DIV < 1) ? 1 : $clog2(DIV + 1);
   localparam logic [DIV_W-1:0]   DIV_LD    = DIV_W'(DIV);
   localparam int                 TICK_W    = $clog2(OVERSAMPLE);
   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(OVERSAMPLE - 1);

   uart_state_e        state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [TICK_W-1:0]  tick_q, tick_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic               txd_q, txd_d;

   logic               tick, bit_end, pop;
   logic [7:0]         fifo_data;
   logic               fifo_full, fifo_empty;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_b   (rst_b),
      .push_i  (tx_vld),
      .data_i  (tx_data),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .cnt_o   (fifo_cnt)
   );

   assign tx_rdy  = ~fifo_full;
   assign txd     = txd_q;
   assign busy    = (state_q != ST_IDLE) || !fifo_empty;
   assign tick    = (div_q == '0);
   assign bit_end = tick && (tick_q == TICK_LAST);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;

      // Divider parks at DIV while idle so each frame starts phase-aligned.
      if (state_q == ST_IDLE || tick) div_d = DIV_LD;
      else                            div_d = div_q - DIV_W'(1);
      if (tick) tick_d = tick_q + TICK_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            // Chain straight into the next start bit when more data waits.
            if (bit_end) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (pop) begin
         shift_d = fifo_data;
         tick_d  = '0;
         bit_d   = '0;
         div_d   = DIV_LD;
      end
   end

   // Line level follows the registered state, so it lags the FSM by one cycle.
   always_comb begin
      txd_d = 1'b1;
      case (state_q)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shift_q[0];
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= ST_IDLE;
         div_q   <= DIV_LD;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: stimulus queues expected bytes, a serial
// receive monitor on txd pops and compares each decoded frame.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int unsigned FCPU = 3072000;
   localparam int unsigned BAUD = 19200;
   localparam int          BITC = OVERSAMPLE * (FCPU / (BAUD * OVERSAMPLE));

   logic       clk;
   logic       rst_b;
   logic       tx_vld;
   logic [7:0] tx_data;
   logic       tx_rdy;
   logic       txd;
   logic       busy;
   logic [2:0] fifo_cnt;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_log[$];
   logic [7:0] fill_b [6];
   logic [7:0] lb_str [3];

   uart_tx #(
      .FCPU       (FCPU),
      .BAUD       (BAUD),
      .FIFO_DEPTH (4)
   ) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .tx_vld   (tx_vld),
      .tx_data  (tx_data),
      .tx_rdy   (tx_rdy),
      .txd      (txd),
      .busy     (busy),
      .fifo_cnt (fifo_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one byte for a single edge; sb selects whether the monitor should expect it.
   task automatic push_byte(input logic [7:0] b, input bit sb);
      @(negedge clk);
      tx_vld  = 1'b1;
      tx_data = b;
      @(posedge clk);
      if (sb) exp_q.push_back(b);
      #1;
      tx_vld = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         cyc(1);
         n++;
      end
      chk("idle_reached", {31'd0, busy}, 32'd0);
   endtask

   // Receive monitor: mid-bit sampling, resynchronised by reset.
   initial begin
      int         m_cnt;
      bit         m_act;
      logic       m_prev;
      logic [7:0] m_sh;
      m_act  = 1'b0;
      m_prev = 1'b1;
      m_cnt  = 0;
      m_sh   = '0;
      forever begin
         @(negedge clk);
         if (rst_b !== 1'b1) begin
            m_act  = 1'b0;
            m_prev = 1'b1;
         end else begin
            if (!m_act) begin
               if (m_prev === 1'b1 && txd === 1'b0) begin
                  m_act = 1'b1;
                  m_cnt = 0;
               end
            end else begin
               m_cnt++;
               if (m_cnt == BITC / 2) begin
                  chk("rx_start_mid", {31'd0, txd}, 32'd0);
               end else if (m_cnt > BITC / 2 && m_cnt < BITC / 2 + 9 * BITC &&
                            (m_cnt - BITC / 2) % BITC == 0) begin
                  m_sh = {txd, m_sh[7:1]};
               end else if (m_cnt == BITC / 2 + 9 * BITC) begin
                  chk("rx_stop", {31'd0, txd}, 32'd1);
                  rx_log.push_back(m_sh);
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL rx_unexpected actual=%0h expected=none at %0t", m_sh, $time);
                  end else begin
                     chk("rx_byte", {24'd0, m_sh}, {24'd0, exp_q.pop_front()});
                  end
                  m_act = 1'b0;
               end
            end
            m_prev = txd;
         end
      end
   end

   initial begin
      int n;
      int lows;
      int base;
      fill_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      lb_str = '{8'h48, 8'h69, 8'h0A};
      rst_b   = 1'b0;
      tx_vld  = 1'b0;
      tx_data = 8'h00;

      // Reset state
      cyc(3);
      chk("rst_txd",    {31'd0, txd},      32'd1);
      chk("rst_rdy",    {31'd0, tx_rdy},   32'd1);
      chk("rst_busy",   {31'd0, busy},     32'd0);
      chk("rst_cnt",    {29'd0, fifo_cnt}, 32'd0);
      @(negedge clk);
      rst_b = 1'b1;
      cyc(2);
      chk("rel_cnt", {29'd0, fifo_cnt}, 32'd0);
      chk("rel_txd", {31'd0, txd},      32'd1);

      // Single byte 0x41: push at N, pop at N+1, start bit N+2..N+161
      push_byte(8'h41, 1'b1);
      chk("single_cnt_push", {29'd0, fifo_cnt}, 32'd1);
      cyc(1);
      chk("single_n1_txd",   {31'd0, txd},      32'd1);
      chk("single_n1_cnt",   {29'd0, fifo_cnt}, 32'd0);
      chk("single_n1_busy",  {31'd0, busy},     32'd1);
      cyc(1);
      chk("single_fall",     {31'd0, txd},      32'd0);
      cyc(159);
      chk("single_start_end", {31'd0, txd},     32'd0);
      cyc(1);
      chk("single_bit0",     {31'd0, txd},      32'd1);
      cyc(1338);
      chk("single_stop_busy", {31'd0, busy},    32'd1);
      chk("single_stop_txd", {31'd0, txd},      32'd1);
      cyc(102);
      chk("single_done_busy", {31'd0, busy},    32'd0);
      cyc(10);

      // Back-to-back 0x55, 0xAA, then 0x33 pushed on the STOP->START pop edge
      push_byte(8'h55, 1'b1);
      push_byte(8'hAA, 1'b1);
      chk("idle_pushpop_cnt", {29'd0, fifo_cnt}, 32'd1);
      cyc(1);
      chk("b2b_fall",         {31'd0, txd},      32'd0);
      cyc(1598);
      chk("b2b_stop1",        {31'd0, txd},      32'd1);
      chk("b2b_cnt_pre",      {29'd0, fifo_cnt}, 32'd1);
      push_byte(8'h33, 1'b1);
      chk("stop_pushpop_cnt", {29'd0, fifo_cnt}, 32'd1);
      chk("b2b_stop1_last",   {31'd0, txd},      32'd1);
      cyc(1);
      chk("b2b_start2",       {31'd0, txd},      32'd0);
      cyc(1599);
      chk("b2b_stop2_last",   {31'd0, txd},      32'd1);
      cyc(1);
      chk("b2b_3200_start3",  {31'd0, txd},      32'd0);
      wait_idle(3000);
      cyc(20);

      // FIFO full: hold tx_vld across six bytes during frame 1
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         tx_data = fill_b[i];
         tx_vld  = 1'b1;
         if (i == 5) begin
            chk("full_cnt", {29'd0, fifo_cnt}, 32'd4);
            chk("full_rdy", {31'd0, tx_rdy},   32'd0);
         end
         n = 0;
         while (tx_rdy !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
         end
         chk("full_rdy_return", {31'd0, tx_rdy}, 32'd1);
         @(posedge clk);
         exp_q.push_back(fill_b[i]);
         @(negedge clk);
      end
      tx_vld = 1'b0;
      wait_idle(12000);
      cyc(20);
      chk("full_sb_drain", exp_q.size(), 32'd0);

      // Mid-frame reset in data bit 3 of 0xC3 (bit 3 = 0), second byte queued
      push_byte(8'hC3, 1'b0);
      push_byte(8'h99, 1'b0);
      cyc(719);
      chk("mrst_bit3_pre", {31'd0, txd}, 32'd0);
      rst_b = 1'b0;
      #1;
      chk("mrst_txd_async", {31'd0, txd},      32'd1);
      chk("mrst_cnt",       {29'd0, fifo_cnt}, 32'd0);
      chk("mrst_busy",      {31'd0, busy},     32'd0);
      repeat (3) @(negedge clk);
      rst_b = 1'b1;
      lows = 0;
      for (int i = 0; i < 2000; i++) begin
         cyc(1);
         if (txd !== 1'b1) lows++;
      end
      chk("mrst_no_residual", lows, 32'd0);
      chk("mrst_cnt_after",   {29'd0, fifo_cnt}, 32'd0);
      chk("mrst_busy_after",  {31'd0, busy},     32'd0);

      // Loopback string "Hi\n"
      base = rx_log.size();
      for (int i = 0; i < 3; i++) push_byte(lb_str[i], 1'b1);
      wait_idle(6000);
      cyc(20);
      chk("lb_len", rx_log.size() - base, 32'd3);
      if (rx_log.size() >= base + 3) begin
         for (int i = 0; i < 3; i++) chk("lb_char", {24'd0, rx_log[base + i]}, {24'd0, lb_str[i]});
      end
      chk("sb_drain", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter FCPU, default 50000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 19200, meaning the serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the transmit FIFO entries; it is a power of 2 and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_b, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port tx_vld, input, 1 bit: the producer offers tx_data.
REQ-007 SHALL have port tx_data, input, 8 bits: the byte to send.
REQ-008 SHALL have port tx_rdy, output, 1 bit: the FIFO can accept a byte.
REQ-009 SHALL have port txd, output, 1 bit: the serial line, idle high.
REQ-010 SHALL have port busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.
REQ-011 SHALL have port fifo_cnt, output, $clog2(FIFO_DEPTH)+1 bits: the FIFO occupancy.

Function
REQ-012 SHALL derive DIV = FCPU/(BAUD*16) - 1 using integer division; one oversample tick is DIV+1 clk cycles.
REQ-013 SHALL make each bit last exactly 16 ticks, i.e. 16*(DIV+1) clk cycles.
REQ-014 SHALL use frame format 8N1: start bit 0, data bits 0..7 LSB first, one stop bit 1.
REQ-015 SHALL accept a byte on any cycle where tx_vld and tx_rdy are both 1; the byte is written to the FIFO that edge.
REQ-016 SHALL drive tx_rdy = (fifo_cnt < FIFO_DEPTH); a pop in the same cycle does not raise tx_rdy while the FIFO is full.
REQ-017 SHALL ignore tx_vld while tx_rdy is 0: no write, no overwrite.
REQ-018 SHALL update fifo_cnt by +1 on a push only, -1 on a pop only, and leave it unchanged on a simultaneous push and pop.
REQ-019 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-020 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-021 SHALL transition IDLE -> START when the FIFO is non-empty: pop the head into shift register, clear the tick and bit counters, reload the divider. txd goes 0 on the cycle after the pop.
REQ-022 SHALL transition START -> DATA after 16 ticks; txd = shift[0].
REQ-023 SHALL stay in DATA for 8 bits of 16 ticks each, shifting right once per bit; bit counter 0..7.
REQ-024 SHALL transition DATA -> STOP after bit 7; txd = 1 for 16 ticks.
REQ-025 SHALL transition STOP -> START directly when the FIFO is non-empty (pop on that edge, no idle gap), else STOP -> IDLE.
REQ-026 SHALL hold the divider at DIV in IDLE so that every frame starts phase-aligned.
REQ-027 SHALL register txd; no combinational path from tx_vld or tx_data to txd.
REQ-028 SHALL drive busy = (state != IDLE) || (fifo_cnt != 0).
REQ-029 SHALL start with a zero-latency write-then-pop when the FIFO is empty in IDLE: push at edge N, pop at N+1, txd falls at N+2.

Reset
REQ-030 SHALL, with rst_b low, force state = IDLE, txd = 1, tx_rdy = 1, busy = 0, fifo_cnt = 0, pointers = 0, divider = DIV, and all counters = 0.
REQ-031 SHALL, on reset asserted mid-frame, abort the frame immediately, set txd to 1 asynchronously, and discard the FIFO contents.
REQ-032 SHALL release reset synchronously in effect: no push or pop on the first edge with rst_b high unless tx_vld is 1.

Structure
REQ-033 SHALL place FSM state encodings (2-bit) and the default BAUD and oversample factor 16 in shared package uart_pkg, reused by the receive-side monitor.
REQ-034 SHALL implement the FIFO as sub-module uart_tx_fifo with push/pop/full/empty/cnt; the divider and FSM stay in uart_tx.

Verification (FCPU=3072000, BAUD=19200 -> DIV=9, bit=160 cycles)
REQ-035 SHALL verify single byte: push 0x41 in IDLE -> txd low at N+2 for 160 cycles, then 1,0,0,0,0,0,1,0 at 160 cycles each, then stop high 160; busy drops after the stop.
REQ-036 SHALL verify back-to-back: push 0x55, 0xAA -> second start bit begins immediately after the first stop bit; total 3200 cycles from first falling edge to final stop end.
REQ-037 SHALL verify FIFO full: hold tx_vld with 6 bytes during frame 1 -> tx_rdy = 0 while fifo_cnt = 4; no byte is lost or duplicated; the receive monitor prints all bytes in order.
REQ-038 SHALL verify simultaneous push and pop: push on the exact STOP -> START pop edge with fifo_cnt = 1 -> fifo_cnt stays 1.
REQ-039 SHALL verify mid-frame reset: assert rst_b in DATA bit 3 -> txd = 1 the same cycle; after release, fifo_cnt = 0 and no residual frame is sent.
REQ-040 SHALL verify loopback: connect txd to the receive monitor input and send the string "Hi\n" -> the monitor log contains exactly "Hi\n".
